// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU response link: frame types, receiver states,
// flag bit positions and the CRC3 / error-frame check helpers.
package alu_pkg;

  typedef enum logic {
    DATA_FRAME = 1'b0,
    CTL_FRAME  = 1'b1
  } frame_type_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_TYPE      = 3'd1,
    RX_PAYLOAD   = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam int FRAME_BITS  = 11;
  localparam int DATA_FRAMES = 4;

  localparam int FLAG_CARRY    = 3;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_ZERO     = 1;
  localparam int FLAG_NEGATIVE = 0;

  // x^3+x+1, init 000, MSB first over {C, 1'b0, FLAGS}
  function automatic logic [2:0] crc3(input logic [36:0] data);
    logic [2:0] crc;
    logic       fb;
    crc = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb  = crc[2] ^ data[i];
      crc = {crc[1], crc[0] ^ fb, fb};
    end
    return crc;
  endfunction

  // Error frame is good when the parity bit matches and both error copies agree
  function automatic logic err_frame_ok(input logic [7:0] payload);
    return (payload[0] == ^payload[7:1]) && (payload[6:4] == payload[3:1]);
  endfunction

endpackage

// File: rtl/alu_rsp_deserializer_if.sv
// Serial input line and decoded response bundle of the ALU response deserializer.
interface alu_rsp_deserializer_if;

  logic        sout;
  logic        rsp_valid;
  logic [31:0] rsp_c;
  logic [3:0]  rsp_flags;
  logic        rsp_is_err;
  logic [2:0]  rsp_err;
  logic        rsp_crc_ok;
  logic        rsp_frame_err;

  modport master (
    input  sout,
    output rsp_valid, rsp_c, rsp_flags, rsp_is_err, rsp_err, rsp_crc_ok, rsp_frame_err
  );

  modport slave (
    output sout,
    input  rsp_valid, rsp_c, rsp_flags, rsp_is_err, rsp_err, rsp_crc_ok, rsp_frame_err
  );

endinterface

// File: rtl/alu_frame_rx.sv
// Bit-level receiver for 11-bit frames (start, type, 8 payload MSB first, stop).
// Reports each completed frame with a one-cycle frame_done pulse.
module alu_frame_rx
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sout,
  output logic        frame_done,
  output frame_type_t frame_type,
  output logic [7:0]  payload,
  output logic        stop_err,
  output logic        line_idle
);

  rx_state_t   state_r, state_s;
  logic [2:0]  bit_cnt_r, bit_cnt_s;
  logic [7:0]  shift_r, shift_s;
  frame_type_t type_r, type_s;
  logic        done_r, done_s;
  logic        stop_err_r, stop_err_s;

  // State and frame-capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RX_IDLE;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      type_r     <= DATA_FRAME;
      done_r     <= 1'b0;
      stop_err_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      type_r     <= type_s;
      done_r     <= done_s;
      stop_err_r <= stop_err_s;
    end
  end

  // Next-state and per-bit capture logic
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    type_s     = type_r;
    done_s     = 1'b0;
    stop_err_s = 1'b0;
    case (state_r)
      RX_IDLE: begin
        if (!sout) begin
          state_s = RX_TYPE;
        end else begin
          state_s = RX_IDLE;
        end
      end
      RX_TYPE: begin
        type_s    = frame_type_t'(sout);
        bit_cnt_s = 3'd0;
        state_s   = RX_PAYLOAD;
      end
      RX_PAYLOAD: begin
        shift_s   = {shift_r[6:0], sout};
        bit_cnt_s = bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          state_s = RX_STOP;
        end else begin
          state_s = RX_PAYLOAD;
        end
      end
      RX_STOP: begin
        done_s = 1'b1;
        if (sout) begin
          stop_err_s = 1'b0;
          state_s    = RX_IDLE;
        end else begin
          // A low stop bit could be the start of a stuck-low line; wait for it to go high
          stop_err_s = 1'b1;
          state_s    = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        if (sout) begin
          state_s = RX_IDLE;
        end else begin
          state_s = RX_WAIT_HIGH;
        end
      end
      default: begin
        state_s = RX_IDLE;
      end
    endcase
  end

  assign frame_done = done_r;
  assign frame_type = type_r;
  assign payload    = shift_r;
  assign stop_err   = stop_err_r;
  assign line_idle  = (state_r == RX_IDLE);

endmodule

// File: rtl/alu_rsp_deserializer.sv
// Response sequencer: assembles 4 data frames + ctl frame (or a lone error frame) into one
// checked response. Optional RSP_TIMEOUT_EN aborts a partial response after TIMEOUT_CYCLES idle.
module alu_rsp_deserializer
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_rsp_deserializer_if.master bus
);

  localparam logic [2:0] FULL_CNT = 3'(DATA_FRAMES);

  logic        frame_done_s;
  frame_type_t frame_type_s;
  logic [7:0]  payload_s;
  logic        stop_err_s;
  logic        line_idle_s;
  logic        timeout_s;

  logic [2:0]  dcnt_r, dcnt_s;
  logic [31:0] c_r, c_s;

  logic        emit_s;
  logic [31:0] nxt_c_s;
  logic [3:0]  nxt_flags_s;
  logic        nxt_is_err_s;
  logic [2:0]  nxt_err_s;
  logic        nxt_crc_ok_s;
  logic        nxt_frame_err_s;

  logic        rsp_valid_r;
  logic [31:0] rsp_c_r;
  logic [3:0]  rsp_flags_r;
  logic        rsp_is_err_r;
  logic [2:0]  rsp_err_r;
  logic        rsp_crc_ok_r;
  logic        rsp_frame_err_r;

  alu_frame_rx u_frame_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .sout       (bus.sout),
    .frame_done (frame_done_s),
    .frame_type (frame_type_s),
    .payload    (payload_s),
    .stop_err   (stop_err_s),
    .line_idle  (line_idle_s)
  );

`ifdef RSP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt_r, idle_cnt_s;

  // Idle-gap counter between frames of a partially received response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_r <= '0;
    end else begin
      idle_cnt_r <= idle_cnt_s;
    end
  end

  // Counter advances only on a high idle line with data buffered
  always_comb begin
    idle_cnt_s = '0;
    timeout_s  = 1'b0;
    if (frame_done_s || (dcnt_r == 3'd0) || !line_idle_s || !bus.sout) begin
      idle_cnt_s = '0;
      timeout_s  = 1'b0;
    end else if (idle_cnt_r == CNT_W'(TIMEOUT_CYCLES)) begin
      idle_cnt_s = '0;
      timeout_s  = 1'b1;
    end else begin
      idle_cnt_s = idle_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      timeout_s  = 1'b0;
    end
  end
`else
  logic unused_s;
  assign timeout_s = 1'b0;
  assign unused_s  = line_idle_s | (TIMEOUT_CYCLES < 1);
`endif

  // Response sequencing and field decode
  always_comb begin
    dcnt_s          = dcnt_r;
    c_s             = c_r;
    emit_s          = 1'b0;
    nxt_c_s         = 32'h0000_0000;
    nxt_flags_s     = 4'h0;
    nxt_is_err_s    = 1'b0;
    nxt_err_s       = 3'b000;
    nxt_crc_ok_s    = 1'b0;
    nxt_frame_err_s = 1'b0;
    if (frame_done_s) begin
      if (stop_err_s) begin
        emit_s          = 1'b1;
        nxt_frame_err_s = 1'b1;
        dcnt_s          = 3'd0;
      end else if (frame_type_s == DATA_FRAME) begin
        if (dcnt_r == FULL_CNT) begin
          emit_s          = 1'b1;
          nxt_frame_err_s = 1'b1;
          dcnt_s          = 3'd0;
        end else begin
          c_s    = {c_r[23:0], payload_s};
          dcnt_s = dcnt_r + 3'd1;
        end
      end else if (!payload_s[7]) begin
        emit_s = 1'b1;
        dcnt_s = 3'd0;
        if (dcnt_r == FULL_CNT) begin
          nxt_c_s      = c_r;
          nxt_flags_s  = payload_s[6:3];
          nxt_crc_ok_s = (crc3({c_r, 1'b0, payload_s[6:3]}) == payload_s[2:0]);
        end else begin
          nxt_frame_err_s = 1'b1;
        end
      end else begin
        emit_s = 1'b1;
        dcnt_s = 3'd0;
        if (dcnt_r == 3'd0) begin
          nxt_is_err_s = 1'b1;
          nxt_err_s    = payload_s[6:4];
          nxt_crc_ok_s = err_frame_ok(payload_s);
        end else begin
          nxt_frame_err_s = 1'b1;
        end
      end
    end else if (timeout_s) begin
      emit_s          = 1'b1;
      nxt_frame_err_s = 1'b1;
      dcnt_s          = 3'd0;
    end else begin
      dcnt_s = dcnt_r;
    end
  end

  // Sequencer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_r <= 3'd0;
      c_r    <= 32'h0000_0000;
    end else begin
      dcnt_r <= dcnt_s;
      c_r    <= c_s;
    end
  end

  // Response outputs: pulse valid, hold fields until the next response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r     <= 1'b0;
      rsp_c_r         <= 32'h0000_0000;
      rsp_flags_r     <= 4'h0;
      rsp_is_err_r    <= 1'b0;
      rsp_err_r       <= 3'b000;
      rsp_crc_ok_r    <= 1'b0;
      rsp_frame_err_r <= 1'b0;
    end else begin
      rsp_valid_r <= emit_s;
      if (emit_s) begin
        rsp_c_r         <= nxt_c_s;
        rsp_flags_r     <= nxt_flags_s;
        rsp_is_err_r    <= nxt_is_err_s;
        rsp_err_r       <= nxt_err_s;
        rsp_crc_ok_r    <= nxt_crc_ok_s;
        rsp_frame_err_r <= nxt_frame_err_s;
      end
    end
  end

  assign bus.rsp_valid     = rsp_valid_r;
  assign bus.rsp_c         = rsp_c_r;
  assign bus.rsp_flags     = rsp_flags_r;
  assign bus.rsp_is_err    = rsp_is_err_r;
  assign bus.rsp_err       = rsp_err_r;
  assign bus.rsp_crc_ok    = rsp_crc_ok_r;
  assign bus.rsp_frame_err = rsp_frame_err_r;

endmodule

// File: tb/tb_alu_rsp_deserializer.sv
// Self-checking bench for alu_rsp_deserializer: vector table, directed corner sequences,
// and randomized frame streams against a queue-based reference model.
module tb_alu_rsp_deserializer;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] c;
    logic [3:0]  flags;
    logic        is_err;
    logic [2:0]  err;
    logic        crc_ok;
    logic        frame_err;
  } rsp_t;

  typedef struct {
    string       name;
    bit          err_rsp;
    logic [31:0] c;
    logic [3:0]  flags;
    bit          crc_flip;
    logic [7:0]  err_p;
    rsp_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rsp_t       exp_q[$];
  rsp_t       obs_q[$];
  logic [7:0] buf_q[$];

  alu_rsp_deserializer_if bus();

  alu_rsp_deserializer #(.TIMEOUT_CYCLES(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic rsp_t mk(input logic [31:0] c, input logic [3:0] f, input logic ie,
                              input logic [2:0] e, input logic ok, input logic fe);
    rsp_t r;
    r = {c, f, ie, e, ok, fe};
    return r;
  endfunction

  function automatic rsp_t dut_rsp();
    return mk(bus.rsp_c, bus.rsp_flags, bus.rsp_is_err, bus.rsp_err, bus.rsp_crc_ok,
              bus.rsp_frame_err);
  endfunction

  // CRC as remainder of polynomial long division by x^3+x+1
  function automatic logic [2:0] ref_crc(input logic [31:0] c, input logic [3:0] f);
    logic [39:0] v;
    v = {c, 1'b0, f, 3'b000};
    for (int b = 39; b >= 3; b--) begin
      if (v[b]) v = v ^ (40'hB << (b - 3));
    end
    return v[2:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: applies one received frame to the response buffer
  task automatic model_frame(input bit is_ctl, input logic [7:0] p, input bit stop_ok);
    logic [31:0] c;
    if (!stop_ok) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
      buf_q.delete();
    end else if (!is_ctl) begin
      if (buf_q.size() == 4) begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
        buf_q.delete();
      end else begin
        buf_q.push_back(p);
      end
    end else if (!p[7]) begin
      if (buf_q.size() == 4) begin
        c = {buf_q[0], buf_q[1], buf_q[2], buf_q[3]};
        exp_q.push_back(mk(c, p[6:3], 0, 0, ref_crc(c, p[6:3]) == p[2:0], 0));
      end else begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
      end
      buf_q.delete();
    end else begin
      if (buf_q.size() == 0) begin
        exp_q.push_back(mk(0, 0, 1, p[6:4], ((^p) == 1'b0) && (p[6:4] == p[3:1]), 0));
      end else begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
      end
      buf_q.delete();
    end
  endtask

  task automatic send_frame(input bit is_ctl, input logic [7:0] p, input bit stop);
    logic [10:0] bits;
    bits = {1'b0, is_ctl, p, stop};
    for (int i = FRAME_BITS - 1; i >= 0; i--) begin
      @(negedge clk);
      bus.sout = bits[i];
    end
    model_frame(is_ctl, p, stop);
  endtask

  task automatic send_status(input logic [31:0] c, input logic [3:0] f, input bit flip);
    for (int j = 3; j >= 0; j--) send_frame(1'b0, c[8*j +: 8], 1'b1);
    send_frame(1'b1, {1'b0, f, ref_crc(c, f) ^ {2'b00, flip}}, 1'b1);
  endtask

  // Response expected exactly one cycle after the stop-sampling edge, one cycle wide
  task automatic check_rsp(input string name, input rsp_t exp);
    @(negedge clk);
    bus.sout = 1'b1;
    chk({name, "_early"}, 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    chk({name, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({name, "_fields"}, 64'(dut_rsp()), 64'(exp));
    @(negedge clk);
    chk({name, "_pulse"}, 64'(bus.rsp_valid), 64'd0);
    chk({name, "_hold"}, 64'(dut_rsp()), 64'(exp));
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid) obs_q.push_back(dut_rsp());
  end

  initial begin
    vec_t        tbl[9];
    logic [3:0]  fl;
    logic [10:0] bits;
    logic [7:0]  p;
    bit          seen;
    int          n;
    int          k;

    fl = 4'((1 << FLAG_CARRY) | (1 << FLAG_ZERO));
    tbl[0] = '{"zero", 0, 32'h0, 4'h0, 0, 8'h00, mk(32'h0, 4'h0, 0, 3'b000, 1, 0)};
    tbl[1] = '{"deadbeef", 0, 32'hDEADBEEF, 4'h0, 0, 8'h00, mk(32'hDEADBEEF, 4'h0, 0, 3'b000, 1, 0)};
    tbl[2] = '{"deadbeef_bad", 0, 32'hDEADBEEF, 4'h0, 1, 8'h00, mk(32'hDEADBEEF, 4'h0, 0, 3'b000, 0, 0)};
    tbl[3] = '{"err93", 1, 32'h0, 4'h0, 0, 8'h93, mk(32'h0, 4'h0, 1, 3'b001, 1, 0)};
    tbl[4] = '{"err92", 1, 32'h0, 4'h0, 0, 8'h92, mk(32'h0, 4'h0, 1, 3'b001, 0, 0)};
    tbl[5] = '{"errC0_copy", 1, 32'h0, 4'h0, 0, 8'hC0, mk(32'h0, 4'h0, 1, 3'b100, 0, 0)};
    tbl[6] = '{"errFF", 1, 32'h0, 4'h0, 0, 8'hFF, mk(32'h0, 4'h0, 1, 3'b111, 1, 0)};
    tbl[7] = '{"s12345678", 0, 32'h12345678, fl, 0, 8'h00, mk(32'h12345678, fl, 0, 3'b000, 1, 0)};
    fl = 4'((1 << FLAG_OVERFLOW) | (1 << FLAG_NEGATIVE) | (1 << FLAG_CARRY) | (1 << FLAG_ZERO));
    tbl[8] = '{"allones", 0, 32'hFFFFFFFF, fl, 0, 8'h00, mk(32'hFFFFFFFF, 4'hF, 0, 3'b000, 1, 0)};

    bus.sout = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({bus.rsp_valid, dut_rsp()}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].err_rsp) send_frame(1'b1, tbl[i].err_p, 1'b1);
      else send_status(tbl[i].c, tbl[i].flags, tbl[i].crc_flip);
      check_rsp(tbl[i].name, tbl[i].exp);
    end

    // Stop bit low on the 2nd data frame, then recovery
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0);
    check_rsp("stop0", mk(0, 0, 0, 0, 0, 1));
    send_status(32'h01020304, 4'b0100, 0);
    check_rsp("after_stop0", mk(32'h01020304, 4'b0100, 0, 3'b000, 1, 0));

    // Sequence violations
    send_frame(1'b0, 8'hAA, 1'b1);
    send_frame(1'b0, 8'hBB, 1'b1);
    send_frame(1'b1, 8'h00, 1'b1);
    check_rsp("ctl_after2", mk(0, 0, 0, 0, 0, 1));
    send_frame(1'b1, 8'h00, 1'b1);
    check_rsp("ctl_after0", mk(0, 0, 0, 0, 0, 1));
    for (int j = 0; j < 3; j++) send_frame(1'b0, 8'(j + 1), 1'b1);
    send_frame(1'b1, 8'h93, 1'b1);
    check_rsp("err_after3", mk(0, 0, 0, 0, 0, 1));
    for (int j = 0; j < 5; j++) send_frame(1'b0, 8'(j + 8'h40), 1'b1);
    check_rsp("five_data", mk(0, 0, 0, 0, 0, 1));

`ifdef RSP_TIMEOUT_EN
    send_frame(1'b0, 8'h55, 1'b1);
    send_frame(1'b0, 8'h66, 1'b1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      bus.sout = 1'b1;
      n++;
      seen = bus.rsp_valid;
    end
    chk("timeout_seen", 64'(seen), 64'd1);
    chk("timeout_rsp", 64'(dut_rsp()), 64'(mk(0, 0, 0, 0, 0, 1)));
    chk("timeout_window", 64'((n >= 64) && (n <= 68)), 64'd1);
    buf_q.delete();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
`else
    send_frame(1'b0, 8'h55, 1'b1);
    send_frame(1'b0, 8'h66, 1'b1);
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      bus.sout = 1'b1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("partial_waits", 64'(seen), 64'd0);
    send_frame(1'b0, 8'h77, 1'b1);
    send_frame(1'b0, 8'h88, 1'b1);
    send_frame(1'b1, {1'b0, 4'b1001, ref_crc(32'h55667788, 4'b1001)}, 1'b1);
    check_rsp("partial_done", mk(32'h55667788, 4'b1001, 0, 3'b000, 1, 0));
`endif

    // Reset in the middle of the 3rd data frame payload
    send_frame(1'b0, 8'h12, 1'b1);
    send_frame(1'b0, 8'h34, 1'b1);
    bits = {1'b0, 1'b0, 8'hA5, 1'b1};
    for (int i = 10; i >= 6; i--) begin
      @(negedge clk);
      bus.sout = bits[i];
    end
    @(negedge clk);
    rst_n = 1'b0;
    bus.sout = 1'b1;
    buf_q.delete();
    #1;
    chk("midreset_outputs", 64'({bus.rsp_valid, dut_rsp()}), 64'd0);
    repeat (2) @(negedge clk);
    chk("midreset_hold", 64'({bus.rsp_valid, dut_rsp()}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_status(32'hCAFEF00D, 4'b0001, 0);
    check_rsp("after_reset", mk(32'hCAFEF00D, 4'b0001, 0, 3'b000, 1, 0));

    // Randomized frame streams against the reference model
    repeat (4) @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    for (int r = 0; r < 40; r++) begin
      k = $urandom_range(0, 9);
      if (k <= 5) begin
        send_status($urandom, 4'($urandom), $urandom_range(0, 3) == 0);
      end else if (k == 6) begin
        p = 8'($urandom);
        p[7] = 1'b1;
        if ($urandom_range(0, 1) == 1) p[0] = ^p[7:1];
        send_frame(1'b1, p, 1'b1);
      end else if (k == 7) begin
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) send_frame(1'b0, 8'($urandom), 1'b1);
        p = 8'($urandom);
        send_frame(1'b1, p, 1'b1);
      end else if (k == 8) begin
        for (int j = 0; j < 5; j++) send_frame(1'b0, 8'($urandom), 1'b1);
      end else begin
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) send_frame(1'b0, 8'($urandom), 1'b1);
        send_frame(1'b0, 8'($urandom), 1'b0);
        @(negedge clk);
        bus.sout = 1'b1;
      end
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        bus.sout = 1'b1;
      end
    end
    repeat (20) @(negedge clk);
    chk("rand_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("rand_rsp%0d", i), 64'(obs_q[i]), 64'(exp_q[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rsp_deserializer.md
Name: alu_rsp_deserializer

Overview:
- Receive end of the serial ALU response line.
- Samples the ALU `sout` bit stream, reassembles 11-bit frames and collects the 4-byte result C plus the control frame.
- Checks framing, CRC3 and parity, then presents one decoded response per operation to the scoreboard/monitor side of the testbench.
- Serial mirror of the serializer that drives operations into the ALU.

Parameters:
- TIMEOUT_CYCLES, 64, max idle-high cycles allowed between frames of one response (used only with RSP_TIMEOUT_EN).

Ports:
- clk  input  1  clock; all sampling on rising edge
- rst_n  input  1  asynchronous active-low reset
- sout  input  1  serial line from ALU, idle high, one bit per clk
- rsp_valid  output  1  one-cycle pulse: response fields valid
- rsp_c  output  32  result C, first data byte = C[31:24]
- rsp_flags  output  4  {carry, overflow, zero, negative}
- rsp_is_err  output  1  response was an error frame
- rsp_err  output  3  {err_data, err_crc, err_op} from error frame
- rsp_crc_ok  output  1  CRC3 (status) or parity/duplicate check (error) passed
- rsp_frame_err  output  1  framing/sequence violation; other fields zero

Behaviour:
- Frame format: start 0, type bit (0 = data, 1 = ctl), 8 payload bits MSB first, stop 1.
- Status response: 4 data frames, then a ctl frame with payload {0, FLAGS[3:0], CRC[2:0]}.
  - CRC3 uses polynomial x^3+x+1, init 000, computed MSB first over {C[31:0], 1'b0, FLAGS}.
- Error response: a single ctl frame with payload {1, ed, ec, eo, ed, ec, eo, P}.
  - P = XOR of payload[7:1].
  - rsp_crc_ok = parity correct AND both copies equal; rsp_err takes the upper copy.
- Frame FSM: IDLE -> TYPE -> PAYLOAD (8 cycles, 3-bit counter) -> STOP -> IDLE.
  - IDLE leaves on sout == 0.
  - Stop sampled 0: go to WAIT_HIGH, which returns to IDLE on the first sout == 1.
- Response sequencer: data-frame counter 0..4, shift register for C.
- rsp_valid rises on the clock edge after the ctl frame stop bit is sampled.
  - Latency: 1 cycle after stop.
  - All rsp_* fields are registered, held until the next rsp_valid, and stable during the pulse.
- Sequence violations: rsp_valid=1, rsp_frame_err=1, partial data discarded, counter cleared. Cases:
  - stop bit 0;
  - status ctl frame after fewer than 4 data frames (0 included);
  - 5th data frame (flagged at its stop);
  - error ctl frame after 1..4 data frames.
- A start bit directly after a stop bit (no idle cycle) is legal: back-to-back frames.
- Reset (any time, including mid-frame): FSM to IDLE, counters 0, all outputs 0, partial response discarded.

Optional Feature:
- RSP_TIMEOUT_EN defined: an idle counter runs in IDLE while 1..4 data frames are buffered.
  - When it reaches TIMEOUT_CYCLES, emit rsp_frame_err with rsp_valid and clear the buffer.
  - The counter resets on every start bit.
- RSP_TIMEOUT_EN undefined: no counter; a partial response waits indefinitely.

Decomposition:
- alu_pkg holds:
  - frame_type_t enum {DATA_FRAME, CTL_FRAME};
  - localparams FRAME_BITS=11, DATA_FRAMES=4;
  - flag bit index constants;
  - function crc3 (shared with the transmit side and the scoreboard).
- Sub-module alu_frame_rx: bit-level frame FSM. Outputs per frame: frame_done pulse, frame_type, payload[7:0], stop_err.
- Top level: response sequencing, CRC/parity checks, timeout.

Test Plan:
- Status response, 4 data frames 0x00 then ctl payload 0x00 -> rsp_valid one cycle after stop; rsp_c=0, flags=0000, crc_ok=1, is_err=0.
- Data frames 0xDE,0xAD,0xBE,0xEF with ctl CRC from model; repeat with CRC bit 0 flipped -> rsp_c=0xDEADBEEF; crc_ok=1, then crc_ok=0.
- Error frame 0x93 alone (err_op, good parity); then 0x92 -> is_err=1, rsp_err=001, crc_ok=1; then crc_ok=0.
- Stop bit forced 0 on 2nd data frame, then a full valid response -> first rsp_frame_err=1; line recovers; second response decoded correctly.
- Ctl frame after 2 data frames; separately, 5 data frames -> rsp_frame_err=1 in both cases.
- rst_n low during 3rd data frame payload, then a full response -> outputs 0 during reset; no rsp_valid from the partial; next response correct.
- With RSP_TIMEOUT_EN and TIMEOUT_CYCLES=64: 2 data frames then 64 idle cycles -> rsp_frame_err pulse.
